adc_capture_sequencer: RTL and testbench
========================================

// Module: adc_capture_sequencer
// PURPOSE
// Sequences AD9284 two-channel capture into the ch1/ch2 Xillybus read FIFOs, configured over the mem_8 address-mapped port.
// Packs 8-bit samples 4-per-32-bit word, counts words per run, drops on FIFO full (sticky flag), signals EOF at run end.
// Sits between the ADC front-end (samples already in bus_clk domain) and xillybus_core; owns the mem_8 register map.
// PARAMETERS
// ADC_W       8      sample width; 4*ADC_W must equal 32
// CNT_W       24     width of word-count and decimation registers
// LED_DIV_W   24     LED heartbeat divider width
// PORTS
// bus_clk_w                in   1   sole clock (Xillybus bus clock)
// bus_rst_w                in   1   synchronous, active-high reset
// user_w_mem_8_wren_w      in   1   register write strobe
// user_w_mem_8_data_w      in   32  register write data
// user_mem_8_addr_w        in   5   register address (write and read)
// user_r_mem_8_rden_w      in   1   register read strobe
// user_r_mem_8_data_w      out  32  register read data
// user_r_mem_8_empty_w     out  1   constant 0
// user_r_mem_8_eof_w       out  1   constant 0
// user_w_mem_8_full_w      out  1   constant 0
// user_r_ch1_read_open_w   in   1   host has ch1 stream open
// user_r_ch2_read_open_w   in   1   host has ch2 stream open
// adc_valid_w              in   1   one-cycle sample strobe, both channels
// adc_ch1_w / adc_ch2_w    in   ADC_W  samples, valid with adc_valid_w
// fifo_ch1_full_w / _ch2   in   1   read-FIFO full
// fifo_ch1_wren_w / _ch2   out  1   FIFO write enable, one cycle per word
// fifo_ch1_din_w / _ch2    out  32  packed word; sample 0 in bits [7:0]
// ch1_eof_w / ch2_eof_w    out  1   to user_r_chN_read_eof_w
// GPIO_LED_w               out  4   {ovf2, ovf1, capturing, heartbeat}
// BEHAVIOUR
// Registers: 0 CTRL rw {[0] arm(self-clearing), [1] ch1_en, [2] ch2_en, [3] abort(self-clearing)}; 1 NWORDS rw (0 = unlimited);
//  2 DECIM rw (keep 1 of DECIM+1 strobes); 3 STATUS ro {[1:0] state, [2] ovf1, [3] ovf2}; 4 CNT1 ro; 5 CNT2 ro; others read 0, writes ignored.
// Read: data registered on rden, valid the cycle after rden; holds last value otherwise.
// Reset: all outputs 0, CTRL=0x6, NWORDS=0, DECIM=0, counters/flags 0, state IDLE.
// FSM: IDLE -arm & (ch1_en|ch2_en)-> ARMED (clears CNTx, ovfx, packer, decim counter).
//  ARMED -read_open true for every enabled channel-> CAPTURE, starting at next kept strobe.
//  CAPTURE -(NWORDS!=0 & every enabled CNTx==NWORDS) | abort | any enabled open drops-> DONE.
//  DONE: chN_eof_w=1 for enabled channels until that channel's open deasserts; all low -> IDLE.
//  abort in IDLE/ARMED -> IDLE directly, no EOF.
// Packing: per kept strobe, sample into slot idx (0..3) of both packers; idx==3 completes word.
// Word complete: if FIFO not full -> wren=1 for 1 cycle, CNTx+=1; else drop word, ovfx=1 (sticky to next arm). Count counts only written words.
// Disabled channel: no wren, CNT stays 0. Partial word at end of run discarded, not flushed.
// Word accepted in the same cycle CNT reaches NWORDS is the last; later strobes ignored.
// CTRL writes to en bits ignored outside IDLE; NWORDS/DECIM writes latched at arm only.
// Arm while not IDLE ignored. Reset mid-capture: immediate return to reset state, no EOF.
// Heartbeat toggles every 2^LED_DIV_W cycles.
// STRUCTURE
// Package adc_cap_pkg: state enum, register address constants, CTRL/STATUS bit indices.
// One sub-module adc_word_packer (instanced per channel): slot index, 32-bit shift/assemble, full check, ovf, word counter.
// Sequencer FSM, register file, decimator and LED logic in top.
// TESTING
// Write NWORDS=4, arm, both open, 16 strobes ch1=0..15 -> ch1 words 0x03020100..0x0F0E0D0C, CNT1=4, ch1_eof_w=1.
// DECIM=1, NWORDS=1, 8 strobes samples 0..7 -> single word 0x06040200.
// Hold fifo_ch2_full high during word 2 of 4 -> that word dropped, STATUS ovf2=1, CNT2 ends 4 after 5th word arrives.
// ch2_en=0, arm -> only ch1 writes; ARMED waits only on ch1 open; ch2_eof_w stays 0.
// NWORDS=0, arm, 3 strobes then abort -> no wren, DONE with EOF; open drop -> IDLE.
// rden at addr 3 during CAPTURE -> data next cycle = 0x2; reset asserted mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Shared definitions for the AD9284 capture sequencer: sequencer states,
// mem_8 register addresses and CTRL/STATUS bit positions.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_t;

  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_NWORDS = 5'd1;
  localparam logic [4:0] ADDR_DECIM  = 5'd2;
  localparam logic [4:0] ADDR_STATUS = 5'd3;
  localparam logic [4:0] ADDR_CNT1   = 5'd4;
  localparam logic [4:0] ADDR_CNT2   = 5'd5;

  localparam int CTRL_ARM    = 0;
  localparam int CTRL_CH1_EN = 1;
  localparam int CTRL_CH2_EN = 2;
  localparam int CTRL_ABORT  = 3;

  localparam int STATUS_OVF1 = 2;
  localparam int STATUS_OVF2 = 3;

endpackage

// File: rtl/adc_word_packer.sv
// Packs four kept samples into one word (sample 0 in the low byte), writes it
// to the read FIFO when there is room, otherwise drops it and flags overflow.
module adc_word_packer #(
  parameter int ADC_W = 8,
  parameter int CNT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               strobe,
  input  logic [ADC_W-1:0]   sample,
  input  logic [CNT_W-1:0]   nwords,
  input  logic               fifo_full,
  output logic               wren,
  output logic [4*ADC_W-1:0] din,
  output logic [CNT_W-1:0]   cnt,
  output logic               ovf
);

  logic [1:0]         idx;
  logic [4*ADC_W-1:0] sh;
  logic               reached;

  // Once the run length is met this channel ignores further strobes.
  assign reached = (nwords != '0) && (cnt == nwords);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= 2'd0;
      sh   <= '0;
      wren <= 1'b0;
      din  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      wren <= 1'b0;
      if (clear) begin
        idx <= 2'd0;
        sh  <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (strobe && !reached) begin
        sh  <= {sample, sh[4*ADC_W-1:ADC_W]};
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          if (fifo_full) begin
            ovf <= 1'b1;
          end else begin
            wren <= 1'b1;
            din  <= {sample, sh[4*ADC_W-1:ADC_W]};
            cnt  <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Two-channel AD9284 capture sequencer: mem_8 register file, run FSM,
// decimator and LED status, feeding the ch1/ch2 Xillybus read FIFOs.
module adc_capture_sequencer
  import adc_cap_pkg::*;
#(
  parameter int ADC_W     = 8,
  parameter int CNT_W     = 24,
  parameter int LED_DIV_W = 24
) (
  input  logic             bus_clk_w,
  input  logic             bus_rst_w,
  input  logic             user_w_mem_8_wren_w,
  input  logic [31:0]      user_w_mem_8_data_w,
  input  logic [4:0]       user_mem_8_addr_w,
  input  logic             user_r_mem_8_rden_w,
  output logic [31:0]      user_r_mem_8_data_w,
  output logic             user_r_mem_8_empty_w,
  output logic             user_r_mem_8_eof_w,
  output logic             user_w_mem_8_full_w,
  input  logic             user_r_ch1_read_open_w,
  input  logic             user_r_ch2_read_open_w,
  input  logic             adc_valid_w,
  input  logic [ADC_W-1:0] adc_ch1_w,
  input  logic [ADC_W-1:0] adc_ch2_w,
  input  logic             fifo_ch1_full_w,
  input  logic             fifo_ch2_full_w,
  output logic             fifo_ch1_wren_w,
  output logic             fifo_ch2_wren_w,
  output logic [31:0]      fifo_ch1_din_w,
  output logic [31:0]      fifo_ch2_din_w,
  output logic             ch1_eof_w,
  output logic             ch2_eof_w,
  output logic [3:0]       GPIO_LED_w
);

  seq_state_t           state;
  logic                 ch1_en, ch2_en, capturing, hb;
  logic [CNT_W-1:0]     nwords_reg, decim_reg, nwords_run, decim_run, dcnt;
  logic [CNT_W-1:0]     cnt1, cnt2;
  logic                 ovf1, ovf2;
  logic [LED_DIV_W-1:0] hb_cnt;
  logic [31:0]          rmux;
  logic                 ctrl_wr, abort_req, arm_go, open_ok, run_end, keep;

  assign user_r_mem_8_empty_w = 1'b0;
  assign user_r_mem_8_eof_w   = 1'b0;
  assign user_w_mem_8_full_w  = 1'b0;
  assign GPIO_LED_w           = {ovf2, ovf1, capturing, hb};

  assign ctrl_wr   = user_w_mem_8_wren_w && (user_mem_8_addr_w == ADDR_CTRL);
  assign abort_req = ctrl_wr && user_w_mem_8_data_w[CTRL_ABORT];
  // Arm uses the enable bits carried by the same write, since they land in IDLE.
  assign arm_go    = (state == ST_IDLE) && ctrl_wr && user_w_mem_8_data_w[CTRL_ARM] && !abort_req
                     && (user_w_mem_8_data_w[CTRL_CH1_EN] || user_w_mem_8_data_w[CTRL_CH2_EN]);
  assign open_ok   = (!ch1_en || user_r_ch1_read_open_w) && (!ch2_en || user_r_ch2_read_open_w);
  assign run_end   = ((nwords_run != '0) && (!ch1_en || cnt1 == nwords_run)
                      && (!ch2_en || cnt2 == nwords_run))
                     || abort_req || !open_ok;
  assign keep      = adc_valid_w && (state == ST_CAPTURE) && (dcnt == '0);

  always_ff @(posedge bus_clk_w) begin
    if (bus_rst_w) begin
      state      <= ST_IDLE;
      ch1_en     <= 1'b1;
      ch2_en     <= 1'b1;
      nwords_run <= '0;
      decim_run  <= '0;
      dcnt       <= '0;
      capturing  <= 1'b0;
      ch1_eof_w  <= 1'b0;
      ch2_eof_w  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_wr) begin
            ch1_en <= user_w_mem_8_data_w[CTRL_CH1_EN];
            ch2_en <= user_w_mem_8_data_w[CTRL_CH2_EN];
          end
          if (arm_go) begin
            state      <= ST_ARMED;
            nwords_run <= nwords_reg;
            decim_run  <= decim_reg;
            dcnt       <= '0;
          end
        end
        ST_ARMED: begin
          if (abort_req) begin
            state <= ST_IDLE;
          end else if (open_ok) begin
            state     <= ST_CAPTURE;
            capturing <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (adc_valid_w) dcnt <= (dcnt == decim_run) ? '0 : dcnt + CNT_W'(1);
          if (run_end) begin
            state     <= ST_DONE;
            capturing <= 1'b0;
            ch1_eof_w <= ch1_en;
            ch2_eof_w <= ch2_en;
          end
        end
        ST_DONE: begin
          ch1_eof_w <= ch1_eof_w && user_r_ch1_read_open_w;
          ch2_eof_w <= ch2_eof_w && user_r_ch2_read_open_w;
          if (!(ch1_eof_w && user_r_ch1_read_open_w) && !(ch2_eof_w && user_r_ch2_read_open_w))
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk_w) begin
    if (bus_rst_w) begin
      nwords_reg <= '0;
      decim_reg  <= '0;
    end else if (user_w_mem_8_wren_w) begin
      if (user_mem_8_addr_w == ADDR_NWORDS) nwords_reg <= user_w_mem_8_data_w[CNT_W-1:0];
      if (user_mem_8_addr_w == ADDR_DECIM)  decim_reg  <= user_w_mem_8_data_w[CNT_W-1:0];
    end
  end

  always_comb begin
    rmux = '0;
    case (user_mem_8_addr_w)
      ADDR_CTRL: begin
        rmux[CTRL_CH1_EN] = ch1_en;
        rmux[CTRL_CH2_EN] = ch2_en;
      end
      ADDR_NWORDS: rmux[CNT_W-1:0] = nwords_reg;
      ADDR_DECIM:  rmux[CNT_W-1:0] = decim_reg;
      ADDR_STATUS: begin
        rmux[1:0]         = state;
        rmux[STATUS_OVF1] = ovf1;
        rmux[STATUS_OVF2] = ovf2;
      end
      ADDR_CNT1:   rmux[CNT_W-1:0] = cnt1;
      ADDR_CNT2:   rmux[CNT_W-1:0] = cnt2;
      default:     rmux = '0;
    endcase
  end

  always_ff @(posedge bus_clk_w) begin
    if (bus_rst_w) begin
      user_r_mem_8_data_w <= '0;
      hb_cnt              <= '0;
      hb                  <= 1'b0;
    end else begin
      if (user_r_mem_8_rden_w) user_r_mem_8_data_w <= rmux;
      hb_cnt <= hb_cnt + LED_DIV_W'(1);
      if (&hb_cnt) hb <= ~hb;
    end
  end

  adc_word_packer #(.ADC_W(ADC_W), .CNT_W(CNT_W)) u_pack1 (
    .clk(bus_clk_w), .rst(bus_rst_w), .clear(arm_go), .strobe(keep && ch1_en),
    .sample(adc_ch1_w), .nwords(nwords_run), .fifo_full(fifo_ch1_full_w),
    .wren(fifo_ch1_wren_w), .din(fifo_ch1_din_w), .cnt(cnt1), .ovf(ovf1)
  );

  adc_word_packer #(.ADC_W(ADC_W), .CNT_W(CNT_W)) u_pack2 (
    .clk(bus_clk_w), .rst(bus_rst_w), .clear(arm_go), .strobe(keep && ch2_en),
    .sample(adc_ch2_w), .nwords(nwords_run), .fifo_full(fifo_ch2_full_w),
    .wren(fifo_ch2_wren_w), .din(fifo_ch2_din_w), .cnt(cnt2), .ovf(ovf2)
  );

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: random strobes against a sample-list model,
// FIFO words checked by a monitor popping per-channel expected queues.
module tb_adc_capture_sequencer;
  import adc_cap_pkg::*;

  logic        bus_clk_w = 1'b0;
  logic        bus_rst_w = 1'b1;
  logic        user_w_mem_8_wren_w = 1'b0;
  logic [31:0] user_w_mem_8_data_w = '0;
  logic [4:0]  user_mem_8_addr_w = '0;
  logic        user_r_mem_8_rden_w = 1'b0;
  logic [31:0] user_r_mem_8_data_w;
  logic        user_r_mem_8_empty_w, user_r_mem_8_eof_w, user_w_mem_8_full_w;
  logic        user_r_ch1_read_open_w = 1'b0, user_r_ch2_read_open_w = 1'b0;
  logic        adc_valid_w = 1'b0;
  logic [7:0]  adc_ch1_w = '0, adc_ch2_w = '0;
  logic        fifo_ch1_full_w = 1'b0, fifo_ch2_full_w = 1'b0;
  logic        fifo_ch1_wren_w, fifo_ch2_wren_w;
  logic [31:0] fifo_ch1_din_w, fifo_ch2_din_w;
  logic        ch1_eof_w, ch2_eof_w;
  logic [3:0]  GPIO_LED_w;

  adc_capture_sequencer #(.ADC_W(8), .CNT_W(24), .LED_DIV_W(4)) dut (
    .bus_clk_w(bus_clk_w), .bus_rst_w(bus_rst_w),
    .user_w_mem_8_wren_w(user_w_mem_8_wren_w), .user_w_mem_8_data_w(user_w_mem_8_data_w),
    .user_mem_8_addr_w(user_mem_8_addr_w), .user_r_mem_8_rden_w(user_r_mem_8_rden_w),
    .user_r_mem_8_data_w(user_r_mem_8_data_w), .user_r_mem_8_empty_w(user_r_mem_8_empty_w),
    .user_r_mem_8_eof_w(user_r_mem_8_eof_w), .user_w_mem_8_full_w(user_w_mem_8_full_w),
    .user_r_ch1_read_open_w(user_r_ch1_read_open_w), .user_r_ch2_read_open_w(user_r_ch2_read_open_w),
    .adc_valid_w(adc_valid_w), .adc_ch1_w(adc_ch1_w), .adc_ch2_w(adc_ch2_w),
    .fifo_ch1_full_w(fifo_ch1_full_w), .fifo_ch2_full_w(fifo_ch2_full_w),
    .fifo_ch1_wren_w(fifo_ch1_wren_w), .fifo_ch2_wren_w(fifo_ch2_wren_w),
    .fifo_ch1_din_w(fifo_ch1_din_w), .fifo_ch2_din_w(fifo_ch2_din_w),
    .ch1_eof_w(ch1_eof_w), .ch2_eof_w(ch2_eof_w), .GPIO_LED_w(GPIO_LED_w)
  );

  // Clock / reset
  always #5 bus_clk_w = ~bus_clk_w;

  // Scoreboard state
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];
  logic [31:0] mon_e1, mon_e2;

  // Reference model: a run is the list of strobes seen while capturing
  bit          m_en[2];
  int          m_cnt[2];
  int          m_grp[2];
  int          m_fill[2];
  bit          m_ovf[2];
  logic [7:0]  m_buf[2][4];
  int          m_nw, m_dec, m_sidx, m_force2;
  bit          m_rand_full;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop expected word whenever a FIFO write is presented
  always @(negedge bus_clk_w) begin
    if (!bus_rst_w && fifo_ch1_wren_w) begin
      if (exp_q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ch1_word: got unexpected write 0x%08h, expected no write", fifo_ch1_din_w);
      end else begin
        mon_e1 = exp_q1.pop_front();
        check("ch1_word", fifo_ch1_din_w, mon_e1);
      end
    end
    if (!bus_rst_w && fifo_ch2_wren_w) begin
      if (exp_q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ch2_word: got unexpected write 0x%08h, expected no write", fifo_ch2_din_w);
      end else begin
        mon_e2 = exp_q2.pop_front();
        check("ch2_word", fifo_ch2_din_w, mon_e2);
      end
    end
  end

  // Driver tasks
  task automatic reg_write(input logic [4:0] addr, input logic [31:0] data);
    @(posedge bus_clk_w); #1;
    user_w_mem_8_wren_w = 1'b1; user_mem_8_addr_w = addr; user_w_mem_8_data_w = data;
    @(posedge bus_clk_w); #1;
    user_w_mem_8_wren_w = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] addr, output logic [31:0] data);
    @(posedge bus_clk_w); #1;
    user_r_mem_8_rden_w = 1'b1; user_mem_8_addr_w = addr;
    @(posedge bus_clk_w); #1;
    user_r_mem_8_rden_w = 1'b0;
    data = user_r_mem_8_data_w;
  endtask

  task automatic model_arm(input bit e1, input bit e2, input int nw, input int dec,
                           input int force2, input bit rf);
    m_en[0] = e1; m_en[1] = e2;
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0; m_grp[c] = 0; m_fill[c] = 0; m_ovf[c] = 1'b0;
    end
    m_nw = nw; m_dec = dec; m_sidx = 0; m_force2 = force2; m_rand_full = rf;
  endtask

  function automatic bit model_done();
    return (m_nw != 0) && (!m_en[0] || m_cnt[0] == m_nw) && (!m_en[1] || m_cnt[1] == m_nw);
  endfunction

  task automatic model_ch(input int ch, input bit kept, input logic [7:0] s, input bit full);
    logic [31:0] w;
    if (!m_en[ch] || !kept) return;
    if (m_nw != 0 && m_cnt[ch] == m_nw) return;
    m_buf[ch][m_fill[ch]] = s;
    m_fill[ch]++;
    if (m_fill[ch] == 4) begin
      w = {m_buf[ch][3], m_buf[ch][2], m_buf[ch][1], m_buf[ch][0]};
      m_fill[ch] = 0;
      m_grp[ch]++;
      if (full) m_ovf[ch] = 1'b1;
      else begin
        m_cnt[ch]++;
        if (ch == 0) exp_q1.push_back(w); else exp_q2.push_back(w);
      end
    end
  endtask

  task automatic strobe(input logic [7:0] s1, input logic [7:0] s2);
    bit kept, f1, f2;
    kept = (m_sidx % (m_dec + 1)) == 0;
    m_sidx++;
    f1 = m_rand_full && ($urandom_range(0, 5) == 0);
    f2 = m_rand_full && ($urandom_range(0, 5) == 0);
    if (m_force2 >= 0) f2 = kept && (m_grp[1] == m_force2) && (m_fill[1] == 3);
    model_ch(0, kept, s1, f1);
    model_ch(1, kept, s2, f2);
    @(posedge bus_clk_w); #1;
    adc_valid_w = 1'b1; adc_ch1_w = s1; adc_ch2_w = s2;
    fifo_ch1_full_w = f1; fifo_ch2_full_w = f2;
    @(posedge bus_clk_w); #1;
    adc_valid_w = 1'b0; fifo_ch1_full_w = 1'b0; fifo_ch2_full_w = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge bus_clk_w);
  endtask

  task automatic close_and_check_idle();
    logic [31:0] rd;
    user_r_ch1_read_open_w = 1'b0; user_r_ch2_read_open_w = 1'b0;
    repeat (2) @(posedge bus_clk_w);
    reg_read(ADDR_STATUS, rd);
    check("status_idle", rd, {28'd0, m_ovf[1], m_ovf[0], 2'd0});
    @(negedge bus_clk_w);
    check("eof_cleared", {30'd0, ch2_eof_w, ch1_eof_w}, 32'd0);
  endtask

  task automatic run_capture(input bit e1, input bit e2, input int nw, input int dec,
                             input bit seq, input int force2, input bit rf);
    logic [31:0] rd;
    int n;
    reg_write(ADDR_NWORDS, 32'(nw));
    reg_write(ADDR_DECIM, 32'(dec));
    user_r_ch1_read_open_w = e1; user_r_ch2_read_open_w = e2;
    model_arm(e1, e2, nw, dec, force2, rf);
    reg_write(ADDR_CTRL, {28'd0, 1'b0, e2, e1, 1'b1});
    repeat (3) @(posedge bus_clk_w);
    n = 0;
    while (!model_done() && n < 300) begin
      if (seq) strobe(8'(n), 8'(n + 128));
      else strobe(8'($urandom), 8'($urandom));
      n++;
    end
    if (!model_done()) begin
      n_cmp++; n_bad++;
      $display("FAIL run_budget: got %0d strobes without completion, required completion", n);
    end
    repeat (4) @(posedge bus_clk_w);
    reg_read(ADDR_CNT1, rd);
    check("cnt1", rd, 32'(m_cnt[0]));
    reg_read(ADDR_CNT2, rd);
    check("cnt2", rd, 32'(m_cnt[1]));
    reg_read(ADDR_STATUS, rd);
    check("status_done", rd, {28'd0, m_ovf[1], m_ovf[0], 2'd3});
    @(negedge bus_clk_w);
    check("eof_done", {30'd0, ch2_eof_w, ch1_eof_w}, {30'd0, e2, e1});
    check("led_done", {28'd0, GPIO_LED_w[3:1]}, {28'd0, m_ovf[1], m_ovf[0], 1'b0});
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    check("q2_drained", 32'(exp_q2.size()), 32'd0);
    close_and_check_idle();
  endtask

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    logic [31:0] rd;
    logic h;
    int n;

    repeat (3) @(posedge bus_clk_w);
    @(negedge bus_clk_w);
    check("rst_din1", fifo_ch1_din_w, 32'd0);
    check("rst_din2", fifo_ch2_din_w, 32'd0);
    check("rst_rdata", user_r_mem_8_data_w, 32'd0);
    check("rst_flags", {21'd0, fifo_ch1_wren_w, fifo_ch2_wren_w, ch1_eof_w, ch2_eof_w, GPIO_LED_w,
          user_r_mem_8_empty_w, user_r_mem_8_eof_w, user_w_mem_8_full_w}, 32'd0);
    #1 bus_rst_w = 1'b0;

    reg_read(ADDR_CTRL, rd);   check("rst_ctrl", rd, 32'h6);
    reg_read(ADDR_NWORDS, rd); check("rst_nwords", rd, 32'd0);
    reg_read(ADDR_DECIM, rd);  check("rst_decim", rd, 32'd0);
    reg_read(ADDR_STATUS, rd); check("rst_status", rd, 32'd0);
    reg_read(5'd9, rd);        check("unmapped_read", rd, 32'd0);

    // Directed: 4 words of ascending samples, decimation, forced ch2 drop, ch2 disabled
    run_capture(1'b1, 1'b1, 4, 0, 1'b1, -1, 1'b0);
    run_capture(1'b1, 1'b1, 1, 1, 1'b1, -1, 1'b0);
    run_capture(1'b1, 1'b1, 4, 0, 1'b0, 1, 1'b0);
    run_capture(1'b1, 1'b0, 3, 0, 1'b0, -1, 1'b1);

    // Unlimited run aborted after 3 strobes, with register checks during CAPTURE
    reg_write(ADDR_NWORDS, 32'd0);
    reg_write(ADDR_DECIM, 32'd0);
    user_r_ch1_read_open_w = 1'b1; user_r_ch2_read_open_w = 1'b1;
    model_arm(1'b1, 1'b1, 0, 0, -1, 1'b0);
    reg_write(ADDR_CTRL, 32'h7);
    repeat (3) @(posedge bus_clk_w);
    for (int i = 0; i < 3; i++) strobe(8'($urandom), 8'($urandom));
    reg_read(ADDR_STATUS, rd); check("status_capture", rd, 32'h2);
    check("led_capturing", {31'd0, GPIO_LED_w[1]}, 32'd1);
    reg_write(ADDR_CTRL, 32'h1);
    reg_read(ADDR_CTRL, rd);   check("ctrl_en_locked", rd, 32'h6);
    reg_read(ADDR_STATUS, rd); check("arm_ignored", rd, 32'h2);
    reg_write(ADDR_CTRL, 32'hE);
    repeat (2) @(posedge bus_clk_w);
    reg_read(ADDR_STATUS, rd); check("status_abort", rd, 32'h3);
    @(negedge bus_clk_w);
    check("eof_abort", {30'd0, ch2_eof_w, ch1_eof_w}, 32'd3);
    check("abort_q_empty", 32'(exp_q1.size() + exp_q2.size()), 32'd0);
    close_and_check_idle();

    // Random runs
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 3);
      run_capture(n[0], n[1], $urandom_range(1, 5), $urandom_range(0, 2), 1'b0, -1, 1'b1);
    end

    // Reset in the middle of a run
    user_r_ch1_read_open_w = 1'b1; user_r_ch2_read_open_w = 1'b1;
    model_arm(1'b1, 1'b1, 0, 0, -1, 1'b0);
    reg_write(ADDR_CTRL, 32'h7);
    repeat (3) @(posedge bus_clk_w);
    for (int i = 0; i < 6; i++) strobe(8'($urandom), 8'($urandom));
    reg_write(ADDR_CTRL, 32'h8);
    repeat (2) @(posedge bus_clk_w);
    user_r_mem_8_rden_w = 1'b1; user_mem_8_addr_w = ADDR_STATUS;
    @(posedge bus_clk_w); #1;
    user_r_mem_8_rden_w = 1'b0;
    bus_rst_w = 1'b1;
    @(posedge bus_clk_w); #1;
    check("midrst_rdata", user_r_mem_8_data_w, 32'd0);
    check("midrst_din", fifo_ch1_din_w | fifo_ch2_din_w, 32'd0);
    check("midrst_flags", {24'd0, fifo_ch1_wren_w, fifo_ch2_wren_w, ch1_eof_w, ch2_eof_w, GPIO_LED_w}, 32'd0);
    bus_rst_w = 1'b0;
    exp_q1.delete(); exp_q2.delete();
    reg_read(ADDR_CTRL, rd);   check("midrst_ctrl", rd, 32'h6);
    reg_read(ADDR_STATUS, rd); check("midrst_status", rd, 32'd0);

    // Heartbeat period with a 4-bit divider
    h = GPIO_LED_w[0];
    n = 0;
    while (GPIO_LED_w[0] == h && n < 100) begin @(negedge bus_clk_w); n++; end
    h = GPIO_LED_w[0];
    n = 0;
    do begin @(negedge bus_clk_w); n++; end while (GPIO_LED_w[0] == h && n < 100);
    check("hb_period", 32'(n), 32'd16);

    repeat (5) @(posedge bus_clk_w);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
